// File: rtl/axi_mem_arbiter.sv
// Single-outstanding AXI arbiter: shares one master port between the IFU (reads)
// and the LSU (reads/writes) with round-robin selection and single-beat transfers.
module axi_mem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter bit LSU_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  // IFU read port
  input  logic [ADDR_W-1:0]   ifu_AR_ADDR,
  input  logic                ifu_AR_VALID,
  output logic                ifu_AR_READY,
  output logic [DATA_W-1:0]   ifu_R_DATA,
  output logic                ifu_R_VALID,
  input  logic                ifu_R_READY,
  // LSU read/write port
  input  logic [ADDR_W-1:0]   lsu_AW_ADDR,
  input  logic                lsu_AW_VALID,
  output logic                lsu_AW_READY,
  input  logic [DATA_W-1:0]   lsu_W_DATA,
  input  logic [DATA_W/8-1:0] lsu_W_STRB,
  input  logic                lsu_W_VALID,
  output logic                lsu_W_READY,
  output logic                lsu_B_VALID,
  input  logic                lsu_B_READY,
  input  logic [ADDR_W-1:0]   lsu_AR_ADDR,
  input  logic                lsu_AR_VALID,
  output logic                lsu_AR_READY,
  output logic [DATA_W-1:0]   lsu_R_DATA,
  output logic                lsu_R_VALID,
  input  logic                lsu_R_READY,
  // Slave-side port
  output logic [ADDR_W-1:0]   axi_AW_ADDR,
  output logic                axi_AW_VALID,
  input  logic                axi_AW_READY,
  output logic [DATA_W-1:0]   axi_W_DATA,
  output logic [DATA_W/8-1:0] axi_W_STRB,
  output logic                axi_W_VALID,
  input  logic                axi_W_READY,
  input  logic                axi_B_VALID,
  output logic                axi_B_READY,
  output logic [ADDR_W-1:0]   axi_AR_ADDR,
  output logic                axi_AR_VALID,
  input  logic                axi_AR_READY,
  input  logic [DATA_W-1:0]   axi_R_DATA,
  input  logic                axi_R_VALID,
  output logic                axi_R_READY,
  // Status
  output logic                arb_busy,
  output logic [1:0]          arb_gnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RD_IFU = 2'd1;
  localparam logic [1:0] RD_LSU = 2'd2;
  localparam logic [1:0] WR_LSU = 2'd3;

  logic [1:0] state_q, state_d;
  logic       last_lsu_q, last_lsu_d;
  logic       ar_done_q, ar_done_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic lsu_req, ifu_req, wr_both_done;

  assign lsu_req      = lsu_AW_VALID | lsu_AR_VALID;
  assign ifu_req      = ifu_AR_VALID;
  assign wr_both_done = aw_done_q & w_done_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_lsu_q <= ~LSU_FIRST;
      ar_done_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_lsu_q <= last_lsu_d;
      ar_done_q  <= ar_done_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

  // Grant is decided only in IDLE and registered, so requests never reach the slave
  // in the same cycle they are raised.
  always_comb begin
    // NOTE: every variable gets a default before the case, otherwise paths that do
    // not assign it would infer a latch.
    state_d    = state_q;
    last_lsu_d = last_lsu_q;
    ar_done_d  = ar_done_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    case (state_q)
      IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (lsu_req && (!ifu_req || !last_lsu_q)) begin
          state_d    = lsu_AW_VALID ? WR_LSU : RD_LSU;
          last_lsu_d = 1'b1;
        end else if (ifu_req) begin
          state_d    = RD_IFU;
          last_lsu_d = 1'b0;
        end
      end
      RD_IFU, RD_LSU: begin
        if (axi_AR_VALID && axi_AR_READY) ar_done_d = 1'b1;
        if (axi_R_VALID && axi_R_READY)   state_d   = IDLE;
      end
      WR_LSU: begin
        if (axi_AW_VALID && axi_AW_READY) aw_done_d = 1'b1;
        if (axi_W_VALID && axi_W_READY)   w_done_d  = 1'b1;
        if (axi_B_VALID && axi_B_READY)   state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner's channels pass straight through; everything else is held at zero.
  always_comb begin
    ifu_AR_READY = 1'b0;
    ifu_R_DATA   = '0;
    ifu_R_VALID  = 1'b0;
    lsu_AW_READY = 1'b0;
    lsu_W_READY  = 1'b0;
    lsu_B_VALID  = 1'b0;
    lsu_AR_READY = 1'b0;
    lsu_R_DATA   = '0;
    lsu_R_VALID  = 1'b0;
    axi_AW_ADDR  = '0;
    axi_AW_VALID = 1'b0;
    axi_W_DATA   = '0;
    axi_W_STRB   = '0;
    axi_W_VALID  = 1'b0;
    axi_B_READY  = 1'b0;
    axi_AR_ADDR  = '0;
    axi_AR_VALID = 1'b0;
    axi_R_READY  = 1'b0;
    arb_gnt      = 2'b00;
    case (state_q)
      RD_IFU: begin
        axi_AR_ADDR  = ifu_AR_ADDR;
        axi_AR_VALID = ifu_AR_VALID & ~ar_done_q;
        ifu_AR_READY = axi_AR_READY & ~ar_done_q;
        ifu_R_DATA   = axi_R_DATA;
        ifu_R_VALID  = axi_R_VALID;
        axi_R_READY  = ifu_R_READY;
        arb_gnt      = 2'b01;
      end
      RD_LSU: begin
        axi_AR_ADDR  = lsu_AR_ADDR;
        axi_AR_VALID = lsu_AR_VALID & ~ar_done_q;
        lsu_AR_READY = axi_AR_READY & ~ar_done_q;
        lsu_R_DATA   = axi_R_DATA;
        lsu_R_VALID  = axi_R_VALID;
        axi_R_READY  = lsu_R_READY;
        arb_gnt      = 2'b10;
      end
      WR_LSU: begin
        axi_AW_ADDR  = lsu_AW_ADDR;
        axi_AW_VALID = lsu_AW_VALID & ~aw_done_q;
        lsu_AW_READY = axi_AW_READY & ~aw_done_q;
        axi_W_DATA   = lsu_W_DATA;
        axi_W_STRB   = lsu_W_STRB;
        axi_W_VALID  = lsu_W_VALID & ~w_done_q;
        lsu_W_READY  = axi_W_READY & ~w_done_q;
        // A response before both halves are accepted is a slave error and is dropped.
        lsu_B_VALID  = axi_B_VALID & wr_both_done;
        axi_B_READY  = lsu_B_READY & wr_both_done;
        arb_gnt      = 2'b10;
      end
      default: ;
    endcase
  end

  assign arb_busy = (state_q != IDLE);

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed bench for axi_mem_arbiter: each task drives one scenario as the slave
// and requesters, and compares outputs against hand-computed values.
module tb_axi_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] ifu_AR_ADDR, lsu_AW_ADDR, lsu_AR_ADDR, axi_AW_ADDR, axi_AR_ADDR;
  logic [DW-1:0] ifu_R_DATA, lsu_W_DATA, lsu_R_DATA, axi_W_DATA, axi_R_DATA;
  logic [DW/8-1:0] lsu_W_STRB, axi_W_STRB;
  logic ifu_AR_VALID, ifu_AR_READY, ifu_R_VALID, ifu_R_READY;
  logic lsu_AW_VALID, lsu_AW_READY, lsu_W_VALID, lsu_W_READY, lsu_B_VALID, lsu_B_READY;
  logic lsu_AR_VALID, lsu_AR_READY, lsu_R_VALID, lsu_R_READY;
  logic axi_AW_VALID, axi_AW_READY, axi_W_VALID, axi_W_READY, axi_B_VALID, axi_B_READY;
  logic axi_AR_VALID, axi_AR_READY, axi_R_VALID, axi_R_READY;
  logic arb_busy;
  logic [1:0] arb_gnt;

  int n_cmp = 0;
  int n_err = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0;

  logic [342:0] all_out;
  assign all_out = {ifu_AR_READY, ifu_R_DATA, ifu_R_VALID, lsu_AW_READY, lsu_W_READY,
                    lsu_B_VALID, lsu_AR_READY, lsu_R_DATA, lsu_R_VALID, axi_AW_ADDR,
                    axi_AW_VALID, axi_W_DATA, axi_W_STRB, axi_W_VALID, axi_B_READY,
                    axi_AR_ADDR, axi_AR_VALID, axi_R_READY, arb_busy, arb_gnt};

  axi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LSU_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_AR_ADDR(ifu_AR_ADDR), .ifu_AR_VALID(ifu_AR_VALID), .ifu_AR_READY(ifu_AR_READY),
    .ifu_R_DATA(ifu_R_DATA), .ifu_R_VALID(ifu_R_VALID), .ifu_R_READY(ifu_R_READY),
    .lsu_AW_ADDR(lsu_AW_ADDR), .lsu_AW_VALID(lsu_AW_VALID), .lsu_AW_READY(lsu_AW_READY),
    .lsu_W_DATA(lsu_W_DATA), .lsu_W_STRB(lsu_W_STRB), .lsu_W_VALID(lsu_W_VALID),
    .lsu_W_READY(lsu_W_READY), .lsu_B_VALID(lsu_B_VALID), .lsu_B_READY(lsu_B_READY),
    .lsu_AR_ADDR(lsu_AR_ADDR), .lsu_AR_VALID(lsu_AR_VALID), .lsu_AR_READY(lsu_AR_READY),
    .lsu_R_DATA(lsu_R_DATA), .lsu_R_VALID(lsu_R_VALID), .lsu_R_READY(lsu_R_READY),
    .axi_AW_ADDR(axi_AW_ADDR), .axi_AW_VALID(axi_AW_VALID), .axi_AW_READY(axi_AW_READY),
    .axi_W_DATA(axi_W_DATA), .axi_W_STRB(axi_W_STRB), .axi_W_VALID(axi_W_VALID),
    .axi_W_READY(axi_W_READY), .axi_B_VALID(axi_B_VALID), .axi_B_READY(axi_B_READY),
    .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID), .axi_AR_READY(axi_AR_READY),
    .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY),
    .arb_busy(arb_busy), .arb_gnt(arb_gnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (axi_AW_VALID && axi_AW_READY) aw_hs++;
    if (axi_W_VALID && axi_W_READY)   w_hs++;
    if (lsu_B_VALID && lsu_B_READY)   b_hs++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_AR_ADDR = '0; ifu_AR_VALID = 0; ifu_R_READY = 0;
    lsu_AW_ADDR = '0; lsu_AW_VALID = 0; lsu_W_DATA = '0; lsu_W_STRB = '0; lsu_W_VALID = 0;
    lsu_B_READY = 0; lsu_AR_ADDR = '0; lsu_AR_VALID = 0; lsu_R_READY = 0;
    axi_AW_READY = 0; axi_W_READY = 0; axi_B_VALID = 0; axi_AR_READY = 0;
    axi_R_DATA = '0; axi_R_VALID = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Owner already granted: accept AR, return one R beat, confirm return to IDLE.
  task automatic serve_read(input bit is_lsu, input logic [DW-1:0] data);
    logic own, oth;
    axi_AR_READY = 1; #1;
    own = is_lsu ? lsu_AR_READY : ifu_AR_READY;
    oth = is_lsu ? ifu_AR_READY : lsu_AR_READY;
    n_cmp++; if (own !== 1'b1) begin n_err++; $display("FAIL rd_own_ar_ready got %b exp 1", own); end
    n_cmp++; if (oth !== 1'b0) begin n_err++; $display("FAIL rd_oth_ar_ready got %b exp 0", oth); end
    tick();
    axi_AR_READY = 0;
    if (is_lsu) lsu_AR_VALID = 0; else ifu_AR_VALID = 0;
    axi_R_VALID = 1; axi_R_DATA = data; ifu_R_READY = 1; lsu_R_READY = 1; #1;
    n_cmp++; if (axi_AR_VALID !== 1'b0) begin n_err++; $display("FAIL rd_ar_reissue got %b exp 0", axi_AR_VALID); end
    own = is_lsu ? lsu_R_VALID : ifu_R_VALID;
    oth = is_lsu ? ifu_R_VALID : lsu_R_VALID;
    n_cmp++; if ((is_lsu ? lsu_R_DATA : ifu_R_DATA) !== data)
      begin n_err++; $display("FAIL rd_data got %h exp %h", is_lsu ? lsu_R_DATA : ifu_R_DATA, data); end
    n_cmp++; if ({own, oth} !== 2'b10) begin n_err++; $display("FAIL rd_r_valid got %b exp 10", {own, oth}); end
    tick();
    axi_R_VALID = 0; axi_R_DATA = '0; #1;
    n_cmp++; if ({arb_busy, arb_gnt} !== 3'b000) begin n_err++; $display("FAIL rd_idle got %b exp 000", {arb_busy, arb_gnt}); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifu_AR_VALID = 1; lsu_AW_VALID = 1; lsu_AR_VALID = 1; lsu_W_VALID = 1;
    ifu_AR_ADDR = 64'h1234; lsu_W_DATA = '1; lsu_W_STRB = '1;
    axi_AR_READY = 1; axi_AW_READY = 1; axi_W_READY = 1; axi_B_VALID = 1;
    axi_R_VALID = 1; axi_R_DATA = 64'hFFFF_0000_FFFF_0000; ifu_R_READY = 1; lsu_B_READY = 1;
    tick();
    n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL reset_outputs got %h exp 0", all_out); end
    clear_inputs();
    rst_n = 1'b1;
    tick();
    n_cmp++; if ({arb_busy, arb_gnt} !== 3'b000) begin n_err++; $display("FAIL reset_idle got %b exp 000", {arb_busy, arb_gnt}); end
  endtask

  task automatic test_ifu_read();
    ifu_AR_ADDR = 64'h8000_0000; ifu_AR_VALID = 1; #1;
    n_cmp++; if ({axi_AR_VALID, arb_gnt} !== 3'b000) begin n_err++; $display("FAIL ifu_same_cycle got %b exp 000", {axi_AR_VALID, arb_gnt}); end
    tick();
    n_cmp++; if (axi_AR_VALID !== 1'b1) begin n_err++; $display("FAIL ifu_ar_valid got %b exp 1", axi_AR_VALID); end
    n_cmp++; if (axi_AR_ADDR !== 64'h8000_0000) begin n_err++; $display("FAIL ifu_ar_addr got %h exp 80000000", axi_AR_ADDR); end
    n_cmp++; if ({arb_busy, arb_gnt} !== 3'b101) begin n_err++; $display("FAIL ifu_gnt got %b exp 101", {arb_busy, arb_gnt}); end
    axi_AR_READY = 1; #1;
    n_cmp++; if (ifu_AR_READY !== 1'b1) begin n_err++; $display("FAIL ifu_ar_ready got %b exp 1", ifu_AR_READY); end
    tick();
    axi_AR_READY = 0; ifu_AR_VALID = 0; ifu_R_READY = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if ({arb_gnt, ifu_R_VALID} !== 3'b010) begin n_err++; $display("FAIL ifu_wait[%0d] got %b exp 010", i, {arb_gnt, ifu_R_VALID}); end
      tick();
    end
    axi_R_VALID = 1; axi_R_DATA = 64'hDEAD_BEEF; #1;
    n_cmp++; if (ifu_R_DATA !== 64'hDEAD_BEEF) begin n_err++; $display("FAIL ifu_r_data got %h exp deadbeef", ifu_R_DATA); end
    n_cmp++; if (ifu_R_VALID !== 1'b1) begin n_err++; $display("FAIL ifu_r_valid got %b exp 1", ifu_R_VALID); end
    tick();
    axi_R_VALID = 0; axi_R_DATA = '0; #1;
    n_cmp++; if ({arb_busy, arb_gnt} !== 3'b000) begin n_err++; $display("FAIL ifu_back_idle got %b exp 000", {arb_busy, arb_gnt}); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    ifu_AR_ADDR = 64'h100; lsu_AR_ADDR = 64'h200;
    ifu_AR_VALID = 1; lsu_AR_VALID = 1;
    tick();
    n_cmp++; if (arb_gnt !== 2'b10) begin n_err++; $display("FAIL rr_first_lsu got %b exp 10", arb_gnt); end
    n_cmp++; if (axi_AR_ADDR !== 64'h200) begin n_err++; $display("FAIL rr_lsu_addr got %h exp 200", axi_AR_ADDR); end
    serve_read(1'b1, 64'hA1);
    lsu_AR_VALID = 1;
    tick();
    n_cmp++; if (arb_gnt !== 2'b01) begin n_err++; $display("FAIL rr_second_ifu got %b exp 01", arb_gnt); end
    serve_read(1'b0, 64'hB2);
    ifu_AR_VALID = 1;
    tick();
    n_cmp++; if (arb_gnt !== 2'b10) begin n_err++; $display("FAIL rr_third_lsu got %b exp 10", arb_gnt); end
    serve_read(1'b1, 64'hC3);
    ifu_AR_VALID = 0;
    tick();
  endtask

  task automatic test_write();
    int aw0, w0, b0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    lsu_AW_ADDR = 64'h8000_1000; lsu_AW_VALID = 1;
    lsu_W_DATA = 64'h1122_3344_5566_7788; lsu_W_STRB = 8'hFF; lsu_W_VALID = 1;
    tick();
    n_cmp++; if ({arb_gnt, axi_AW_VALID, axi_W_VALID} !== 4'b1011) begin n_err++; $display("FAIL wr_grant got %b exp 1011", {arb_gnt, axi_AW_VALID, axi_W_VALID}); end
    n_cmp++; if ({axi_AW_ADDR, axi_W_DATA, axi_W_STRB} !== {64'h8000_1000, 64'h1122_3344_5566_7788, 8'hFF})
      begin n_err++; $display("FAIL wr_payload got %h/%h/%h exp 80001000/1122334455667788/ff", axi_AW_ADDR, axi_W_DATA, axi_W_STRB); end
    axi_W_READY = 1;
    tick();
    axi_W_READY = 0; lsu_W_VALID = 0; axi_W_READY = 1;
    axi_B_VALID = 1; lsu_B_READY = 1; #1;
    n_cmp++; if ({axi_W_VALID, lsu_W_READY} !== 2'b00) begin n_err++; $display("FAIL wr_w_masked got %b exp 00", {axi_W_VALID, lsu_W_READY}); end
    n_cmp++; if ({lsu_B_VALID, axi_B_READY} !== 2'b00) begin n_err++; $display("FAIL wr_early_b got %b exp 00", {lsu_B_VALID, axi_B_READY}); end
    tick();
    axi_W_READY = 0; axi_B_VALID = 0; lsu_B_READY = 0;
    axi_AW_READY = 1; #1;
    n_cmp++; if ({arb_busy, lsu_AW_READY} !== 2'b11) begin n_err++; $display("FAIL wr_aw_ready got %b exp 11", {arb_busy, lsu_AW_READY}); end
    tick();
    axi_AW_READY = 0; lsu_AW_VALID = 0;
    axi_B_VALID = 1; lsu_B_READY = 1; #1;
    n_cmp++; if (lsu_B_VALID !== 1'b1) begin n_err++; $display("FAIL wr_b_valid got %b exp 1", lsu_B_VALID); end
    tick();
    axi_B_VALID = 0; lsu_B_READY = 0; #1;
    n_cmp++; if ({arb_busy, arb_gnt} !== 3'b000) begin n_err++; $display("FAIL wr_back_idle got %b exp 000", {arb_busy, arb_gnt}); end
    n_cmp++; if ({aw_hs - aw0, w_hs - w0, b_hs - b0} !== {32'd1, 32'd1, 32'd1})
      begin n_err++; $display("FAIL wr_hs_counts got %0d/%0d/%0d exp 1/1/1", aw_hs - aw0, w_hs - w0, b_hs - b0); end
  endtask

  task automatic test_mixed();
    apply_reset();
    ifu_AR_ADDR = 64'h3000; ifu_AR_VALID = 1;
    lsu_AR_ADDR = 64'h4000; lsu_AR_VALID = 1;
    lsu_AW_ADDR = 64'h5000; lsu_AW_VALID = 1;
    lsu_W_DATA = 64'h0F0F; lsu_W_STRB = 8'h03; lsu_W_VALID = 1;
    tick();
    n_cmp++; if ({arb_gnt, axi_AW_VALID, axi_AR_VALID} !== 4'b1010) begin n_err++; $display("FAIL mix_write_first got %b exp 1010", {arb_gnt, axi_AW_VALID, axi_AR_VALID}); end
    n_cmp++; if ({lsu_AR_READY, ifu_AR_READY, axi_W_STRB} !== {2'b00, 8'h03}) begin n_err++; $display("FAIL mix_pending got %h exp 003", {lsu_AR_READY, ifu_AR_READY, axi_W_STRB}); end
    axi_AW_READY = 1; axi_W_READY = 1; #1;
    n_cmp++; if ({lsu_AW_READY, lsu_W_READY} !== 2'b11) begin n_err++; $display("FAIL mix_aw_w_same got %b exp 11", {lsu_AW_READY, lsu_W_READY}); end
    tick();
    axi_AW_READY = 0; axi_W_READY = 0; lsu_AW_VALID = 0; lsu_W_VALID = 0;
    axi_B_VALID = 1; lsu_B_READY = 1; #1;
    n_cmp++; if (lsu_B_VALID !== 1'b1) begin n_err++; $display("FAIL mix_b_valid got %b exp 1", lsu_B_VALID); end
    tick();
    axi_B_VALID = 0; lsu_B_READY = 0;
    tick();
    n_cmp++; if ({arb_gnt, axi_AR_ADDR} !== {2'b01, 64'h3000}) begin n_err++; $display("FAIL mix_ifu_second got %b/%h exp 01/3000", arb_gnt, axi_AR_ADDR); end
    serve_read(1'b0, 64'h33);
    tick();
    n_cmp++; if ({arb_gnt, axi_AR_ADDR} !== {2'b10, 64'h4000}) begin n_err++; $display("FAIL mix_lsu_third got %b/%h exp 10/4000", arb_gnt, axi_AR_ADDR); end
    serve_read(1'b1, 64'h44);
  endtask

  task automatic test_reset_mid();
    ifu_AR_ADDR = 64'h6000; ifu_AR_VALID = 1;
    tick();
    axi_AR_READY = 1;
    tick();
    axi_AR_READY = 0; ifu_AR_VALID = 0; ifu_R_READY = 1; #1;
    n_cmp++; if ({arb_busy, arb_gnt, axi_R_READY} !== 4'b1011) begin n_err++; $display("FAIL mid_awaiting_r got %b exp 1011", {arb_busy, arb_gnt, axi_R_READY}); end
    rst_n = 1'b0; #1;
    n_cmp++; if (all_out !== '0) begin n_err++; $display("FAIL mid_async_clear got %h exp 0", all_out); end
    tick();
    rst_n = 1'b1;
    tick();
    ifu_AR_ADDR = 64'h7000; ifu_AR_VALID = 1;
    tick();
    n_cmp++; if ({arb_gnt, axi_AR_VALID, axi_AR_ADDR} !== {2'b01, 1'b1, 64'h7000})
      begin n_err++; $display("FAIL mid_regrant got %b/%b/%h exp 01/1/7000", arb_gnt, axi_AR_VALID, axi_AR_ADDR); end
    serve_read(1'b0, 64'h77);
  endtask

  task automatic test_stall();
    ifu_AR_ADDR = 64'h9000_0040; ifu_AR_VALID = 1;
    tick();
    lsu_AR_ADDR = 64'hA000; lsu_AR_VALID = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if ({axi_AR_VALID, axi_AR_ADDR} !== {1'b1, 64'h9000_0040})
        begin n_err++; $display("FAIL stall_ar[%0d] got %b/%h exp 1/90000040", i, axi_AR_VALID, axi_AR_ADDR); end
      n_cmp++; if ({lsu_AR_READY, lsu_R_VALID, arb_gnt} !== 4'b0001)
        begin n_err++; $display("FAIL stall_nonowner[%0d] got %b exp 0001", i, {lsu_AR_READY, lsu_R_VALID, arb_gnt}); end
      tick();
    end
    serve_read(1'b0, 64'h99);
    tick();
    n_cmp++; if (arb_gnt !== 2'b10) begin n_err++; $display("FAIL stall_lsu_after got %b exp 10", arb_gnt); end
    serve_read(1'b1, 64'hAA);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_write();
    test_mixed();
    test_reset_mid();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
